// File: rtl/rom_load_sequencer.sv
// Bridges the HPS ioctl download stream to the game core ROM port: forwards index-0 bytes,
// checks their order and length, keeps a checksum and holds the core in reset until a good image is loaded.
module rom_load_sequencer #(
  parameter logic [31:0] ROM_SIZE = 32'h0004_0000,
  parameter logic [15:0] RST_HOLD = 16'd1024
) (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic        DL_ACT,
  input  logic [7:0]  DL_IDX,
  input  logic        DL_WR,
  input  logic [24:0] DL_AD,
  input  logic [7:0]  DL_DT,
  input  logic        RST_REQ,
  output logic [24:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic [3:0]  TNO,
  output logic        CORE_RST,
  output logic        LOAD_OK,
  output logic        LOAD_ERR,
  output logic [15:0] CKSUM,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic        act_q;
  logic [24:0] cnt, cnt_nx, cnt_inc;
  logic [15:0] hold, hold_nx;
  logic [15:0] cksum_nx;
  logic [3:0]  tno_nx;
  logic        ok_nx, err_nx;
  logic        romen_nx;
  logic [24:0] romad_nx;
  logic [7:0]  romdt_nx;
  logic        rise, fall, wr0, wr1, bad_wr, hold_last;

  // DL_WR is a one-cycle strobe with no back-pressure; a byte counts only while the
  // registered DL_ACT is high. Edges of DL_ACT take effect on the clock edge where
  // act_q changes, so a write in the fall cycle is still taken before the length compare.
  assign rise      = DL_ACT & ~act_q;
  assign fall      = ~DL_ACT & act_q;
  assign wr0       = DL_WR & act_q & (DL_IDX == 8'd0);
  assign wr1       = DL_WR & act_q & (DL_IDX == 8'd1);
  assign cnt_inc   = (cnt == 25'h1FF_FFFF) ? cnt : cnt + 25'd1;
  assign bad_wr    = (DL_AD != cnt) || ({7'd0, cnt} >= ROM_SIZE);
  assign hold_last = ({1'b0, hold} + 17'd1) >= {1'b0, RST_HOLD};

  assign CORE_RST  = (state != S_RUN);
  assign DBG_STATE = state;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hold_nx  = hold;
    cksum_nx = CKSUM;
    tno_nx   = TNO;
    ok_nx    = LOAD_OK;
    err_nx   = LOAD_ERR;
    romen_nx = 1'b0;
    romad_nx = ROMAD;
    romdt_nx = ROMDT;

    if (wr1) tno_nx = DL_DT[3:0];

    case (state)
      S_IDLE, S_ERR, S_RUN: begin
        if (rise && (DL_IDX == 8'd0)) begin
          state_nx = S_LOAD;
          cnt_nx   = 25'd0;
          cksum_nx = 16'd0;
          ok_nx    = 1'b0;
          err_nx   = 1'b0;
        end else if ((state == S_RUN) && (RST_REQ || wr1)) begin
          state_nx = S_HOLD;
          hold_nx  = 16'd0;
        end
      end
      S_LOAD: begin
        if (wr0) begin
          cksum_nx = CKSUM + {8'd0, DL_DT};
          cnt_nx   = cnt_inc;
          if (bad_wr) begin
            state_nx = S_ERR;
            err_nx   = 1'b1;
          end else begin
            romen_nx = 1'b1;
            romad_nx = DL_AD;
            romdt_nx = DL_DT;
          end
        end
        // An out-of-order byte in the fall cycle already decided the outcome.
        if (fall && (state_nx == S_LOAD)) begin
          if ({7'd0, cnt_nx} == ROM_SIZE) begin
            state_nx = S_HOLD;
            hold_nx  = 16'd0;
            ok_nx    = 1'b1;
          end else begin
            state_nx = S_ERR;
            err_nx   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (RST_REQ || wr1) begin
          hold_nx = 16'd0;
        end else if (hold_last) begin
          state_nx = S_RUN;
          hold_nx  = 16'd0;
        end else begin
          hold_nx = hold + 16'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // act_q resets high so a download still running at reset release is not seen as a rise.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      act_q    <= 1'b1;
      cnt      <= 25'd0;
      hold     <= 16'd0;
      CKSUM    <= 16'd0;
      TNO      <= 4'd0;
      LOAD_OK  <= 1'b0;
      LOAD_ERR <= 1'b0;
      ROMEN    <= 1'b0;
      ROMAD    <= 25'd0;
      ROMDT    <= 8'd0;
    end else begin
      state    <= state_nx;
      act_q    <= DL_ACT;
      cnt      <= cnt_nx;
      hold     <= hold_nx;
      CKSUM    <= cksum_nx;
      TNO      <= tno_nx;
      LOAD_OK  <= ok_nx;
      LOAD_ERR <= err_nx;
      ROMEN    <= romen_nx;
      ROMAD    <= romad_nx;
      ROMDT    <= romdt_nx;
    end
  end

endmodule
